psimd_exec_sequencer: RTL and testbench
=======================================

Name: psimd_exec_sequencer

Overview:
Single-issue controller in front of the 4-lane DLFloat16 SIMD execution unit. It accepts one vector FP instruction per valid/ready handshake and registers the operands and control fields. It drives the execution unit for a fixed number of cycles, captures the 64-bit and integer results, and returns them over a valid/ready response channel. It also keeps RISC-V-style sticky exception flags, OR-reduced across the enabled lanes.

Parameters:
REG_WIDTH, 64, vector register width; 4 lanes x 16 bit.
EU_LATENCY, 1, cycles the execution unit inputs are held before results are sampled; legal range 1..15.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
req_valid  input  1  instruction valid.
req_ready  output  1  sequencer can accept an instruction.
req_ena  input  4  execution-unit operation enable code.
req_rm  input  3  rounding mode; 3'b111 = dynamic.
req_sel1  input  2  operation sub-select.
req_sel2  input  3  compare sub-select.
req_op  input  1  op modifier.
req_lane_en  input  4  lane mask used for flag accumulation.
req_src1, req_src2, req_src3  input  REG_WIDTH  FP operands.
req_srci_0, req_srci_1  input  REG_WIDTH  integer operands.
frm  input  3  dynamic rounding mode from CSR.
eu_ena  output  4  to execution unit.
eu_rm  output  3  to execution unit.
eu_sel1  output  2  to execution unit.
eu_sel2  output  3  to execution unit.
eu_op  output  1  to execution unit.
eu_data1, eu_data2, eu_data3, eu_datai_0, eu_datai_1  output  REG_WIDTH  to execution unit.
eu_dataout_1, eu_dataouti_0, eu_dataouti_1  input  REG_WIDTH  from execution unit.
eu_invalid, eu_inexact, eu_overflow, eu_underflow, eu_div_by_zero  input  4  per-lane flags.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer accepts response.
rsp_data, rsp_datai_0, rsp_datai_1  output  REG_WIDTH  captured results.
rsp_illegal  output  1  instruction rejected because of an illegal rounding mode.
fflags  output  5  sticky flags {NV,DZ,OF,UF,NX}.
fflags_clr  input  1  clear sticky flags.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. req_ready = (state==IDLE) and is combinational from state only.
- Reset: state=IDLE. Every output register is 0: eu_*, rsp_*, fflags, counter. Reset mid-EXEC or mid-RESP abandons the instruction and drops it without a response.
- IDLE, on req_valid&&req_ready: latch all req_* fields. Effective rm = (req_rm==7) ? frm : req_rm, with frm sampled in the accept cycle.
  - If effective rm is in {5,6,7}: the instruction is illegal. Go to RESP next cycle with rsp_illegal=1, rsp_data/rsp_datai_*=0, no flag update, and eu_ena stays 0.
  - Otherwise go to EXEC and load cnt=EU_LATENCY.
- EXEC: eu_ena = latched ena and eu_rm = effective rm. Operands are stable for the whole of EXEC. cnt decrements each cycle. In the cycle cnt==1, results and flags are sampled at the clock edge, then state goes to RESP.
- Latency: for an instruction accepted in cycle N, rsp_valid is first high in cycle N+1+EU_LATENCY. For an illegal instruction, rsp_valid is high in cycle N+1.
- Outside EXEC, eu_ena=0. The other eu_* outputs hold their last latched values.
- RESP: rsp_valid=1 and all rsp_* are stable until rsp_valid&&rsp_ready. On that handshake go to IDLE and clear rsp_valid and rsp_illegal. Throughput is at most one instruction per EU_LATENCY+2 cycles. rsp_ready is ignored outside RESP.
- Flag accumulation happens at the sample edge only:
  - fflags[4] |= |(eu_invalid & lane_en)
  - fflags[3] |= |(eu_div_by_zero & lane_en)
  - fflags[2] |= |(eu_overflow & lane_en)
  - fflags[1] |= |(eu_underflow & lane_en)
  - fflags[0] |= |(eu_inexact & lane_en)
- fflags_clr in the same cycle as a sample edge: clear is applied first, then the new flags are ORed in, so the new flags survive.
- req_valid may drop before it is accepted; there is no requirement that it stays high.

Test Plan:
- EU_LATENCY=1, ena=4'b0001, rm=0, a single add: accepted at cycle 0 -> eu_ena=1 in cycle 1 only; rsp_valid rises in cycle 2; rsp_data equals the model output; busy is 1 for cycles 1-2.
- req_rm=7 with frm=3'b101 -> rsp_valid in cycle 1, rsp_illegal=1, rsp_data=0, eu_ena never asserted, fflags unchanged.
- EU_LATENCY=3; eu_overflow=4'b1000 with lane_en=4'b0111, then eu_overflow=4'b0100 with lane_en=4'b0100 -> fflags=5'b00000 after the first instruction and 5'b00100 after the second.
- rsp_ready held low for 5 cycles in RESP -> rsp_* stable, req_ready=0; a second req_valid is not accepted until the cycle after rsp_ready=1.
- fflags=5'b10001 with fflags_clr coinciding with a sample edge where eu_inexact=4'b0001 and lane_en=4'b1111 -> fflags=5'b00001.
- rst asserted in the second EXEC cycle (EU_LATENCY=3) -> next cycle: state IDLE, req_ready=1, rsp_valid=0, fflags=0, eu_ena=0; no response emitted afterwards.

Source files
------------

// File: rtl/psimd_exec_sequencer_if.sv
// ============================================================================
// Module      : psimd_exec_sequencer_if
// Description : Request/response bundle for the PSIMD execution sequencer.
//               Request channel: valid/ready plus instruction control fields
//               and the three FP and two integer operands.
//               Response channel: valid/ready plus captured FP result, two
//               integer results and the illegal-rounding-mode indication.
//               slave  : sequencer side (accepts requests, returns responses)
//               master : issuing side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psimd_exec_sequencer_if #(
    parameter int REG_WIDTH = 64
);
    // request channel
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_ena;
    logic [2:0]           req_rm;
    logic [1:0]           req_sel1;
    logic [2:0]           req_sel2;
    logic                 req_op;
    logic [3:0]           req_lane_en;
    logic [REG_WIDTH-1:0] req_src1;
    logic [REG_WIDTH-1:0] req_src2;
    logic [REG_WIDTH-1:0] req_src3;
    logic [REG_WIDTH-1:0] req_srci_0;
    logic [REG_WIDTH-1:0] req_srci_1;

    // response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_WIDTH-1:0] rsp_data;
    logic [REG_WIDTH-1:0] rsp_datai_0;
    logic [REG_WIDTH-1:0] rsp_datai_1;
    logic                 rsp_illegal;

    modport slave (
        input  req_valid, req_ena, req_rm, req_sel1, req_sel2, req_op,
               req_lane_en, req_src1, req_src2, req_src3, req_srci_0, req_srci_1,
        output req_ready,
        output rsp_valid, rsp_data, rsp_datai_0, rsp_datai_1, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_ena, req_rm, req_sel1, req_sel2, req_op,
               req_lane_en, req_src1, req_src2, req_src3, req_srci_0, req_srci_1,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_datai_0, rsp_datai_1, rsp_illegal,
        output rsp_ready
    );
endinterface

`default_nettype wire

// File: rtl/psimd_exec_sequencer.sv
// ============================================================================
// Module      : psimd_exec_sequencer
// Description : Single-issue controller in front of the 4-lane DLFloat16 SIMD
//               execution unit. Accepts one instruction per handshake, holds
//               the execution-unit inputs for EU_LATENCY cycles, samples the
//               results and per-lane flags, returns a response and keeps
//               sticky {NV,DZ,OF,UF,NX} flags over the enabled lanes.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               bus (slave)         - request / response channels
//               frm                 - dynamic rounding mode (CSR)
//               eu_*  (out)         - control and operands to execution unit
//               eu_dataout*/flags   - results and per-lane flags from the unit
//               fflags, fflags_clr  - sticky flags and their clear strobe
//               busy                - instruction in flight
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psimd_exec_sequencer #(
    parameter int REG_WIDTH  = 64,
    parameter int EU_LATENCY = 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    psimd_exec_sequencer_if.slave     bus,
    input  wire logic [2:0]           frm,
    output logic      [3:0]           eu_ena,
    output logic      [2:0]           eu_rm,
    output logic      [1:0]           eu_sel1,
    output logic      [2:0]           eu_sel2,
    output logic                      eu_op,
    output logic      [REG_WIDTH-1:0] eu_data1,
    output logic      [REG_WIDTH-1:0] eu_data2,
    output logic      [REG_WIDTH-1:0] eu_data3,
    output logic      [REG_WIDTH-1:0] eu_datai_0,
    output logic      [REG_WIDTH-1:0] eu_datai_1,
    input  wire logic [REG_WIDTH-1:0] eu_dataout_1,
    input  wire logic [REG_WIDTH-1:0] eu_dataouti_0,
    input  wire logic [REG_WIDTH-1:0] eu_dataouti_1,
    input  wire logic [3:0]           eu_invalid,
    input  wire logic [3:0]           eu_inexact,
    input  wire logic [3:0]           eu_overflow,
    input  wire logic [3:0]           eu_underflow,
    input  wire logic [3:0]           eu_div_by_zero,
    output logic      [4:0]           fflags,
    input  wire logic                 fflags_clr,
    output logic                      busy
);

    localparam logic [3:0] c_eu_latency = 4'(EU_LATENCY);
    localparam logic [2:0] c_rm_dyn     = 3'd7;
    localparam logic [2:0] c_rm_max     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]           r_cnt;
    logic [3:0]           r_eu_ena;
    logic [2:0]           r_eu_rm;
    logic [1:0]           r_eu_sel1;
    logic [2:0]           r_eu_sel2;
    logic                 r_eu_op;
    logic [REG_WIDTH-1:0] r_eu_data1;
    logic [REG_WIDTH-1:0] r_eu_data2;
    logic [REG_WIDTH-1:0] r_eu_data3;
    logic [REG_WIDTH-1:0] r_eu_datai_0;
    logic [REG_WIDTH-1:0] r_eu_datai_1;
    logic [3:0]           r_lane_en;
    logic                 r_rsp_valid;
    logic                 r_rsp_illegal;
    logic [REG_WIDTH-1:0] r_rsp_data;
    logic [REG_WIDTH-1:0] r_rsp_datai_0;
    logic [REG_WIDTH-1:0] r_rsp_datai_1;
    logic [4:0]           r_fflags;

    logic [2:0] w_eff_rm;
    logic       w_rm_illegal;
    logic       w_accept;
    logic       w_sample;
    logic       w_rsp_done;
    logic [4:0] w_new_flags;

    // frm is only meaningful in the accept cycle; it is folded into the
    // latched rounding mode there and never looked at again.
    assign w_eff_rm     = (bus.req_rm == c_rm_dyn) ? frm : bus.req_rm;
    assign w_rm_illegal = (w_eff_rm > c_rm_max);
    assign w_accept     = bus.req_valid && (r_state == ST_IDLE);
    // The counter reaches 1 in the last cycle the unit inputs are held.
    assign w_sample     = (r_state == ST_EXEC) && (r_cnt == 4'd1);
    assign w_rsp_done   = (r_state == ST_RESP) && bus.rsp_ready;

    assign w_new_flags = {|(eu_invalid     & r_lane_en),
                          |(eu_div_by_zero & r_lane_en),
                          |(eu_overflow    & r_lane_en),
                          |(eu_underflow   & r_lane_en),
                          |(eu_inexact     & r_lane_en)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_rm_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_sample) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_rsp_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_eu_ena      <= 4'd0;
            r_eu_rm       <= 3'd0;
            r_eu_sel1     <= 2'd0;
            r_eu_sel2     <= 3'd0;
            r_eu_op       <= 1'b0;
            r_eu_data1    <= '0;
            r_eu_data2    <= '0;
            r_eu_data3    <= '0;
            r_eu_datai_0  <= '0;
            r_eu_datai_1  <= '0;
            r_lane_en     <= 4'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_datai_0 <= '0;
            r_rsp_datai_1 <= '0;
            r_fflags      <= 5'd0;
        end else begin
            if (w_accept) begin
                r_eu_rm      <= w_eff_rm;
                r_eu_sel1    <= bus.req_sel1;
                r_eu_sel2    <= bus.req_sel2;
                r_eu_op      <= bus.req_op;
                r_eu_data1   <= bus.req_src1;
                r_eu_data2   <= bus.req_src2;
                r_eu_data3   <= bus.req_src3;
                r_eu_datai_0 <= bus.req_srci_0;
                r_eu_datai_1 <= bus.req_srci_1;
                r_lane_en    <= bus.req_lane_en;
                if (w_rm_illegal) begin
                    // Rejected: answer immediately, never enable the unit.
                    r_rsp_valid   <= 1'b1;
                    r_rsp_illegal <= 1'b1;
                    r_rsp_data    <= '0;
                    r_rsp_datai_0 <= '0;
                    r_rsp_datai_1 <= '0;
                end else begin
                    r_eu_ena <= bus.req_ena;
                    r_cnt    <= c_eu_latency;
                end
            end

            if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_sample) begin
                r_eu_ena      <= 4'd0;
                r_rsp_valid   <= 1'b1;
                r_rsp_data    <= eu_dataout_1;
                r_rsp_datai_0 <= eu_dataouti_0;
                r_rsp_datai_1 <= eu_dataouti_1;
            end

            if (w_rsp_done) begin
                r_rsp_valid   <= 1'b0;
                r_rsp_illegal <= 1'b0;
            end

            // A clear coinciding with a sample edge wipes the old flags but
            // keeps the ones produced by this instruction.
            if (w_sample) begin
                r_fflags <= (fflags_clr ? 5'd0 : r_fflags) | w_new_flags;
            end else if (fflags_clr) begin
                r_fflags <= 5'd0;
            end
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign busy            = (r_state != ST_IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_datai_0 = r_rsp_datai_0;
    assign bus.rsp_datai_1 = r_rsp_datai_1;

    assign eu_ena     = r_eu_ena;
    assign eu_rm      = r_eu_rm;
    assign eu_sel1    = r_eu_sel1;
    assign eu_sel2    = r_eu_sel2;
    assign eu_op      = r_eu_op;
    assign eu_data1   = r_eu_data1;
    assign eu_data2   = r_eu_data2;
    assign eu_data3   = r_eu_data3;
    assign eu_datai_0 = r_eu_datai_0;
    assign eu_datai_1 = r_eu_datai_1;
    assign fflags     = r_fflags;

endmodule

`default_nettype wire

// File: tb/tb_psimd_exec_sequencer.sv
// ============================================================================
// Module      : tb_psimd_exec_sequencer
// Description : Self-checking bench for psimd_exec_sequencer. Two instances
//               (EU_LATENCY 3 and 1) share the request stimulus; dsel picks
//               which one is driven and observed. Each instance sees a small
//               behavioural execution unit whose outputs are only meaningful
//               while eu_ena is non-zero, so mistimed sampling shows up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psimd_exec_sequencer;

    localparam int RW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   dsel;   // 0 -> EU_LATENCY=3 instance, 1 -> EU_LATENCY=1 instance

    logic        t_req_valid, t_rsp_ready, t_clr, t_op;
    logic [3:0]  t_ena, t_lane, t_nv, t_dz, t_of, t_uf, t_nx;
    logic [2:0]  t_rm, t_frm, t_sel2;
    logic [1:0]  t_sel1;
    logic [63:0] t_src1, t_src2, t_src3, t_i0, t_i1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] m_flags [2];

    function automatic logic [63:0] lane_mix(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r ^ c;
    endfunction

    psimd_exec_sequencer_if #(.REG_WIDTH(RW)) bus_a ();
    psimd_exec_sequencer_if #(.REG_WIDTH(RW)) bus_b ();

    assign bus_a.req_valid   = t_req_valid && (dsel == 0);
    assign bus_a.rsp_ready   = t_rsp_ready && (dsel == 0);
    assign bus_a.req_ena     = t_ena;
    assign bus_a.req_rm      = t_rm;
    assign bus_a.req_sel1    = t_sel1;
    assign bus_a.req_sel2    = t_sel2;
    assign bus_a.req_op      = t_op;
    assign bus_a.req_lane_en = t_lane;
    assign bus_a.req_src1    = t_src1;
    assign bus_a.req_src2    = t_src2;
    assign bus_a.req_src3    = t_src3;
    assign bus_a.req_srci_0  = t_i0;
    assign bus_a.req_srci_1  = t_i1;

    assign bus_b.req_valid   = t_req_valid && (dsel == 1);
    assign bus_b.rsp_ready   = t_rsp_ready && (dsel == 1);
    assign bus_b.req_ena     = t_ena;
    assign bus_b.req_rm      = t_rm;
    assign bus_b.req_sel1    = t_sel1;
    assign bus_b.req_sel2    = t_sel2;
    assign bus_b.req_op      = t_op;
    assign bus_b.req_lane_en = t_lane;
    assign bus_b.req_src1    = t_src1;
    assign bus_b.req_src2    = t_src2;
    assign bus_b.req_src3    = t_src3;
    assign bus_b.req_srci_0  = t_i0;
    assign bus_b.req_srci_1  = t_i1;

    logic [3:0]  eu_ena [2], eu_nv [2], eu_nx [2], eu_of [2], eu_uf [2], eu_dz [2];
    logic [2:0]  eu_rm [2], eu_sel2 [2];
    logic [1:0]  eu_sel1 [2];
    logic        eu_op [2], busy_w [2], clr_w [2];
    logic [63:0] eu_d1 [2], eu_d2 [2], eu_d3 [2], eu_di0 [2], eu_di1 [2];
    logic [63:0] eu_o1 [2], eu_oi0 [2], eu_oi1 [2];
    logic [4:0]  fflags_w [2];

    assign clr_w[0] = t_clr && (dsel == 0);
    assign clr_w[1] = t_clr && (dsel == 1);

    for (genvar k = 0; k < 2; k++) begin : g_eu
        logic act;
        assign act       = (eu_ena[k] != 4'h0);
        assign eu_o1[k]  = act ? lane_mix(eu_d1[k], eu_d2[k], eu_d3[k]) : 64'hBAD0_BAD0_BAD0_BAD0;
        assign eu_oi0[k] = act ? eu_di0[k] + eu_di1[k] : '1;
        assign eu_oi1[k] = act ? eu_di1[k] ^ {eu_op[k], eu_sel2[k], eu_sel1[k], eu_rm[k], 55'd0} : '0;
        assign eu_nv[k]  = act ? t_nv : 4'h0;
        assign eu_dz[k]  = act ? t_dz : 4'h0;
        assign eu_of[k]  = act ? t_of : 4'h0;
        assign eu_uf[k]  = act ? t_uf : 4'h0;
        assign eu_nx[k]  = act ? t_nx : 4'h0;
    end

    psimd_exec_sequencer #(.REG_WIDTH(RW), .EU_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .bus(bus_a), .frm(t_frm),
        .eu_ena(eu_ena[0]), .eu_rm(eu_rm[0]), .eu_sel1(eu_sel1[0]), .eu_sel2(eu_sel2[0]),
        .eu_op(eu_op[0]), .eu_data1(eu_d1[0]), .eu_data2(eu_d2[0]), .eu_data3(eu_d3[0]),
        .eu_datai_0(eu_di0[0]), .eu_datai_1(eu_di1[0]),
        .eu_dataout_1(eu_o1[0]), .eu_dataouti_0(eu_oi0[0]), .eu_dataouti_1(eu_oi1[0]),
        .eu_invalid(eu_nv[0]), .eu_inexact(eu_nx[0]), .eu_overflow(eu_of[0]),
        .eu_underflow(eu_uf[0]), .eu_div_by_zero(eu_dz[0]),
        .fflags(fflags_w[0]), .fflags_clr(clr_w[0]), .busy(busy_w[0])
    );

    psimd_exec_sequencer #(.REG_WIDTH(RW), .EU_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .bus(bus_b), .frm(t_frm),
        .eu_ena(eu_ena[1]), .eu_rm(eu_rm[1]), .eu_sel1(eu_sel1[1]), .eu_sel2(eu_sel2[1]),
        .eu_op(eu_op[1]), .eu_data1(eu_d1[1]), .eu_data2(eu_d2[1]), .eu_data3(eu_d3[1]),
        .eu_datai_0(eu_di0[1]), .eu_datai_1(eu_di1[1]),
        .eu_dataout_1(eu_o1[1]), .eu_dataouti_0(eu_oi0[1]), .eu_dataouti_1(eu_oi1[1]),
        .eu_invalid(eu_nv[1]), .eu_inexact(eu_nx[1]), .eu_overflow(eu_of[1]),
        .eu_underflow(eu_uf[1]), .eu_div_by_zero(eu_dz[1]),
        .fflags(fflags_w[1]), .fflags_clr(clr_w[1]), .busy(busy_w[1])
    );

    // view of the selected instance
    logic        o_req_ready, o_rsp_valid, o_rsp_illegal, o_busy;
    logic [63:0] o_rsp_data, o_rsp_i0, o_rsp_i1;
    logic [4:0]  o_fflags;
    logic [3:0]  o_eu_ena;
    logic [2:0]  o_eu_rm;

    always_comb begin
        if (dsel == 1) begin
            o_req_ready = bus_b.req_ready;   o_rsp_valid = bus_b.rsp_valid;
            o_rsp_illegal = bus_b.rsp_illegal; o_busy = busy_w[1];
            o_rsp_data = bus_b.rsp_data;     o_rsp_i0 = bus_b.rsp_datai_0;
            o_rsp_i1 = bus_b.rsp_datai_1;    o_fflags = fflags_w[1];
            o_eu_ena = eu_ena[1];            o_eu_rm = eu_rm[1];
        end else begin
            o_req_ready = bus_a.req_ready;   o_rsp_valid = bus_a.rsp_valid;
            o_rsp_illegal = bus_a.rsp_illegal; o_busy = busy_w[0];
            o_rsp_data = bus_a.rsp_data;     o_rsp_i0 = bus_a.rsp_datai_0;
            o_rsp_i1 = bus_a.rsp_datai_1;    o_fflags = fflags_w[0];
            o_eu_ena = eu_ena[0];            o_eu_rm = eu_rm[0];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, t=%0t): got=%h expected=%h", tag, dsel, $time, got, exp);
        end
    endtask

    // One clock: apply clear/sample effects to the reference flags, advance
    // to the next falling edge where outputs are observed.
    task automatic tick(input bit sample, input logic [4:0] newf);
        if (t_clr) m_flags[dsel] = 5'd0;
        if (sample) m_flags[dsel] = m_flags[dsel] | newf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_clr(input bit en);
        t_clr = en ? ($urandom_range(0, 5) == 0) : 1'b0;
    endtask

    task automatic rand_operands();
        t_src1 = {$urandom, $urandom}; t_src2 = {$urandom, $urandom};
        t_src3 = {$urandom, $urandom}; t_i0 = {$urandom, $urandom};
        t_i1 = {$urandom, $urandom};
        t_sel1 = 2'($urandom); t_sel2 = 3'($urandom); t_op = 1'($urandom);
    endtask

    // Fields presented while busy; they must never be taken.
    task automatic garbage();
        rand_operands();
        t_req_valid = 1'($urandom);
        t_ena = 4'($urandom); t_rm = 3'($urandom); t_lane = 4'($urandom);
        t_frm = 3'($urandom);
    endtask

    task automatic load_req(input logic [3:0] ena, input logic [2:0] rm, input logic [2:0] frm,
                            input logic [3:0] lane);
        rand_operands();
        t_ena = ena; t_rm = rm; t_frm = frm; t_lane = lane;
    endtask

    task automatic load_flags(input logic [3:0] nv, input logic [3:0] dz, input logic [3:0] of,
                              input logic [3:0] uf, input logic [3:0] nx);
        t_nv = nv; t_dz = dz; t_of = of; t_uf = uf; t_nx = nx;
    endtask

    task automatic idle(input int n, input bit clr_rand);
        for (int i = 0; i < n; i++) begin
            t_req_valid = 1'b0;
            rand_clr(clr_rand);
            tick(1'b0, 5'd0);
            check_eq("idle_rsp_valid", o_rsp_valid, 0);
            check_eq("idle_fflags", o_fflags, m_flags[dsel]);
        end
    endtask

    // Issue the instruction held in t_* (entered at a falling edge) and
    // follow it cycle by cycle until its response has been consumed.
    task automatic run_txn(input int stall, input bit clr_rand, input bit clr_at_sample);
        logic [2:0]  eff;
        bit          ill;
        int          lat, resp_at;
        logic [4:0]  newf;
        logic [3:0]  exp_ena;
        logic [63:0] exp_d, exp_i0, exp_i1;

        eff     = (t_rm == 3'd7) ? t_frm : t_rm;
        ill     = (eff >= 3'd5);
        lat     = (dsel == 1) ? 1 : 3;
        resp_at = ill ? 1 : 1 + lat;
        newf    = {|(t_nv & t_lane), |(t_dz & t_lane), |(t_of & t_lane),
                   |(t_uf & t_lane), |(t_nx & t_lane)};
        exp_ena = t_ena;
        exp_d   = ill ? 64'd0 : lane_mix(t_src1, t_src2, t_src3);
        exp_i0  = ill ? 64'd0 : t_i0 + t_i1;
        exp_i1  = ill ? 64'd0 : t_i1 ^ {t_op, t_sel2, t_sel1, eff, 55'd0};

        check_eq("accept_req_ready", o_req_ready, 1);
        check_eq("accept_busy", o_busy, 0);
        t_req_valid = 1'b1;
        t_rsp_ready = 1'b0;
        rand_clr(clr_rand);
        tick(1'b0, 5'd0);

        for (int c = 1; c < resp_at; c++) begin
            check_eq("exec_rsp_valid", o_rsp_valid, 0);
            check_eq("exec_busy", o_busy, 1);
            check_eq("exec_req_ready", o_req_ready, 0);
            check_eq("exec_eu_ena", o_eu_ena, exp_ena);
            check_eq("exec_eu_rm", o_eu_rm, eff);
            check_eq("exec_fflags", o_fflags, m_flags[dsel]);
            garbage();
            if (clr_at_sample && c == lat) t_clr = 1'b1;
            else rand_clr(clr_rand);
            tick(c == lat, newf);
        end

        check_eq("resp_valid", o_rsp_valid, 1);
        check_eq("resp_illegal", o_rsp_illegal, ill);
        check_eq("resp_data", o_rsp_data, exp_d);
        check_eq("resp_datai_0", o_rsp_i0, exp_i0);
        check_eq("resp_datai_1", o_rsp_i1, exp_i1);
        check_eq("resp_eu_ena", o_eu_ena, 0);
        check_eq("resp_busy", o_busy, 1);
        check_eq("resp_fflags", o_fflags, m_flags[dsel]);

        for (int s = 0; s < stall; s++) begin
            garbage();
            t_rsp_ready = 1'b0;
            rand_clr(clr_rand);
            tick(1'b0, 5'd0);
            check_eq("stall_rsp_valid", o_rsp_valid, 1);
            check_eq("stall_rsp_data", o_rsp_data, exp_d);
            check_eq("stall_req_ready", o_req_ready, 0);
            check_eq("stall_fflags", o_fflags, m_flags[dsel]);
        end

        t_req_valid = 1'b0;
        t_rsp_ready = 1'b1;
        rand_clr(clr_rand);
        tick(1'b0, 5'd0);
        t_rsp_ready = 1'($urandom);   // ignored outside RESP
        t_clr = 1'b0;
        check_eq("done_rsp_valid", o_rsp_valid, 0);
        check_eq("done_rsp_illegal", o_rsp_illegal, 0);
        check_eq("done_req_ready", o_req_ready, 1);
        check_eq("done_busy", o_busy, 0);
        check_eq("done_fflags", o_fflags, m_flags[dsel]);
    endtask

    initial begin
        rst = 1'b1; dsel = 0;
        t_req_valid = 1'b0; t_rsp_ready = 1'b0; t_clr = 1'b0;
        load_req(4'h1, 3'd0, 3'd0, 4'hF);
        load_flags(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        m_flags[0] = 5'd0; m_flags[1] = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            check_eq("rst_req_ready", o_req_ready, 1);
            check_eq("rst_rsp_valid", o_rsp_valid, 0);
            check_eq("rst_busy", o_busy, 0);
            check_eq("rst_fflags", o_fflags, 0);
            check_eq("rst_eu_ena", o_eu_ena, 0);
            check_eq("rst_rsp_data", o_rsp_data, 0);
        end
        rst = 1'b0;
        dsel = 1;
        idle(1, 1'b0);

        // latency 1: plain add, then an illegal dynamic rounding mode
        load_req(4'b0001, 3'd0, 3'd0, 4'hF);
        run_txn(0, 1'b0, 1'b0);
        load_req(4'b0001, 3'd7, 3'b101, 4'hF);
        load_flags(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        run_txn(0, 1'b0, 1'b0);
        check_eq("illegal_fflags_unchanged", o_fflags, 5'b00000);

        // latency 3: masked overflow then an enabled-lane overflow
        dsel = 0;
        idle(1, 1'b0);
        load_req(4'h2, 3'd1, 3'd0, 4'b0111);
        load_flags(4'h0, 4'h0, 4'b1000, 4'h0, 4'h0);
        run_txn(0, 1'b0, 1'b0);
        check_eq("ovf_masked", o_fflags, 5'b00000);
        load_req(4'h2, 3'd1, 3'd0, 4'b0100);
        load_flags(4'h0, 4'h0, 4'b0100, 4'h0, 4'h0);
        run_txn(0, 1'b0, 1'b0);
        check_eq("ovf_enabled", o_fflags, 5'b00100);

        // response held for five cycles
        load_req(4'h3, 3'd2, 3'd0, 4'hF);
        load_flags(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_txn(5, 1'b0, 1'b0);

        // clear coinciding with a sample edge
        t_clr = 1'b1;
        tick(1'b0, 5'd0);
        t_clr = 1'b0;
        load_req(4'h4, 3'd0, 3'd0, 4'hF);
        load_flags(4'b0001, 4'h0, 4'h0, 4'h0, 4'b0001);
        run_txn(0, 1'b0, 1'b0);
        check_eq("flags_nv_nx", o_fflags, 5'b10001);
        load_req(4'h4, 3'd0, 3'd0, 4'hF);
        load_flags(4'h0, 4'h0, 4'h0, 4'h0, 4'b0001);
        run_txn(0, 1'b0, 1'b1);
        check_eq("clr_at_sample", o_fflags, 5'b00001);

        // randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            dsel = int'($urandom_range(0, 1));
            t_req_valid = 1'b0;
            idle(int'($urandom_range(0, 2)), 1'b1);
            load_req(4'($urandom_range(1, 15)), 3'($urandom), 3'($urandom), 4'($urandom));
            load_flags(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            run_txn(int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        // reset in the second EXEC cycle of a latency-3 instruction
        dsel = 0;
        idle(1, 1'b0);
        load_req(4'h5, 3'd0, 3'd0, 4'hF);
        load_flags(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        t_req_valid = 1'b1;
        tick(1'b0, 5'd0);
        t_req_valid = 1'b0;
        check_eq("pre_rst_eu_ena", o_eu_ena, 4'h5);
        tick(1'b0, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_flags[0] = 5'd0; m_flags[1] = 5'd0;
        check_eq("midrst_req_ready", o_req_ready, 1);
        check_eq("midrst_rsp_valid", o_rsp_valid, 0);
        check_eq("midrst_fflags", o_fflags, 0);
        check_eq("midrst_eu_ena", o_eu_ena, 0);
        check_eq("midrst_busy", o_busy, 0);
        idle(6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
